edit_field_sequencer: RTL and testbench
=======================================

EDIT_FIELD_SEQUENCER -- requirements
Module: edit_field_sequencer

Interface
REQ-001 SHALL have parameter REP_DELAY, 50_000_000, cycles a held Up/Dw button must stay high after its rising edge before auto-repeat starts.
REQ-002 SHALL have parameter REP_RATE, 10_000_000, cycles between consecutive auto-repeat pulses.
REQ-003 SHALL have port Clock_in  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset_in  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Tick_1s  input  1  one-cycle 1 Hz timebase pulse.
REQ-006 SHALL have ports Btn_Edit, Btn_Next, Btn_Up, Btn_Dw  input  1 each  debounced level buttons.
REQ-007 SHALL have ports Sec_max, Min_max, Hr_max, Day_max, Mon_max  input  1 each  counter currently at terminal value.
REQ-008 SHALL have ports Up, Dw  output  1 each  one-cycle count-direction pulses to all counters.
REQ-009 SHALL have ports STC, MTC, HTC, DF, MF, AF  output  1 each  counter enables: seconds, minutes, hours, day, month, year.
REQ-010 SHALL have port Edit  output  1  high while in EDIT state.
REQ-011 SHALL have port Field  output  3  selected field index 0..5 (seg, min, hr, day, month, year).

Function
REQ-012 SHALL implement FSM with states RUN and EDIT; all outputs registered.
REQ-013 SHALL detect button rising edges against a registered previous sample.
REQ-014 In RUN, Tick_1s SHALL produce, on the next cycle only: Up=1, STC=1, MTC=Sec_max, HTC=Sec_max&Min_max, DF=previous term&Hr_max, MF=previous term&Day_max, AF=previous term&Mon_max.
REQ-015 Btn_Edit rise in RUN SHALL enter EDIT with Field=0; a coincident Tick_1s SHALL still issue its REQ-014 pulse.
REQ-016 In EDIT, Tick_1s SHALL be ignored.
REQ-017 Btn_Next rise in EDIT SHALL increment Field; 5 SHALL wrap to 0.
REQ-018 Btn_Up (Btn_Dw) rise in EDIT SHALL produce, next cycle, one cycle of Up (Dw) plus only the enable selected by Field.
REQ-019 A button held continuously SHALL produce a further pulse REP_DELAY cycles after its rise, then every REP_RATE cycles until release.
REQ-020 Btn_Up and Btn_Dw both high SHALL produce no pulse and clear the repeat counter; Up and Dw SHALL never be high together.
REQ-021 Btn_Edit rise in EDIT SHALL return to RUN, set Field=0, suppress any coincident Up/Dw pulse, and clear the repeat counter.
REQ-022 Btn_Next rise coincident with an Up/Dw rise SHALL apply the field change and suppress the pulse.
REQ-023 All enables SHALL be 0 in any cycle without an Up or Dw pulse.

Reset
REQ-024 Reset_in low SHALL immediately force state RUN, Field=0, Edit=0, Up=Dw=0, all enables 0, repeat counter 0.
REQ-025 Button previous-sample registers SHALL reset to 1 so buttons held through reset produce no edge.
REQ-026 Reset mid-repeat SHALL abort repeat; no pulse SHALL appear until a fresh rising edge after release.

Structure
REQ-027 Shared package SHALL hold state encoding (RUN, EDIT) and field constants FLD_SEG=0, FLD_MIN=1, FLD_HR=2, FLD_DIA=3, FLD_MES=4, FLD_AO=5.
REQ-028 Edge detection plus auto-repeat SHALL be sub-module btn_repeat, instantiated for Btn_Up and Btn_Dw.
REQ-029 Repeat counter width SHALL be clog2(max(REP_DELAY,REP_RATE)+1).

Verification (REP_DELAY=8, REP_RATE=4)
REQ-030 RUN, Sec_max=1, Min_max=1, Hr_max=0, Tick_1s pulse -> next cycle Up=1, STC=MTC=HTC=1, DF=MF=AF=0, one cycle.
REQ-031 Btn_Edit rise, 3 Btn_Next rises -> Edit=1, Field=3; Btn_Up rise -> one cycle Up=1, DF=1, others 0.
REQ-032 EDIT, Field=1, Btn_Dw held 20 cycles -> Dw+MTC pulses at cycles 1, 9, 13, 17 after rise, none after release.
REQ-033 EDIT, Field=5, Btn_Next rise -> Field=0; Tick_1s in EDIT -> no pulse.
REQ-034 Btn_Up and Btn_Dw rise together -> no pulse; Btn_Edit and Btn_Up rise together in EDIT -> RUN, Field=0, no pulse.
REQ-035 Reset_in low during repeat with Btn_Up held -> outputs 0 at once; after release of reset, held button gives no pulse until re-pressed.

Source files
------------

// File: rtl/edit_field_sequencer_pkg.sv
// Shared definitions for the clock/calendar edit sequencer: FSM state
// encoding, field indices and small helpers used by the top and btn_repeat.
package edit_field_sequencer_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      EDIT = 1'b1
   } seq_state_t;

   // Field indices; bit position in the enable vector matches the index
   localparam logic [2:0] FLD_SEG = 3'd0;
   localparam logic [2:0] FLD_MIN = 3'd1;
   localparam logic [2:0] FLD_HR  = 3'd2;
   localparam logic [2:0] FLD_DIA = 3'd3;
   localparam logic [2:0] FLD_MES = 3'd4;
   localparam logic [2:0] FLD_AO  = 3'd5;

   // One-hot enable vector {AF, MF, DF, HTC, MTC, STC} for a selected field
   function automatic logic [5:0] field_enable(input logic [2:0] field);
      logic [5:0] en;
      en = 6'b000000;
      case (field)
         FLD_SEG: en = 6'b000001;
         FLD_MIN: en = 6'b000010;
         FLD_HR:  en = 6'b000100;
         FLD_DIA: en = 6'b001000;
         FLD_MES: en = 6'b010000;
         FLD_AO:  en = 6'b100000;
         default: en = 6'b000000;
      endcase
      return en;
   endfunction

   // Next field with wrap from the year field back to seconds
   function automatic logic [2:0] next_field(input logic [2:0] field);
      logic [2:0] nxt;
      if (field >= FLD_AO) begin
         nxt = FLD_SEG;
      end else begin
         nxt = field + 3'd1;
      end
      return nxt;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/edit_field_sequencer_btn_repeat.sv
// Rising-edge detector with hold-to-repeat for one debounced button.
// pulse_req is a single-cycle request; the caller registers it.
module btn_repeat
   import edit_field_sequencer_pkg::*;
#(
   parameter int REP_DELAY = 50_000_000,
   parameter int REP_RATE  = 10_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   input  logic clear,
   output logic pulse_req
);

   localparam int CNT_W = $clog2(max_int(REP_DELAY, REP_RATE) + 1);
   localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(REP_DELAY);
   localparam logic [CNT_W-1:0] RATE_C  = CNT_W'(REP_RATE);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

   logic             prev;
   logic             repeating;
   logic [CNT_W-1:0] cnt;
   logic             rise;
   logic             delay_hit;
   logic             rate_hit;

   // A count of zero means idle: only a fresh rising edge restarts timing,
   // so clearing mid-hold (or reset) stops repeats until the next press.
   assign rise      = btn & ~prev;
   assign delay_hit = (cnt == DELAY_C) & ~repeating;
   assign rate_hit  = (cnt == RATE_C) & repeating;
   assign pulse_req = btn & ~clear & (rise | delay_hit | rate_hit);

   // Previous sample plus cycles-since-last-pulse counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev      <= 1'b1;
         cnt       <= '0;
         repeating <= 1'b0;
      end else begin
         prev <= btn;
         if (!btn || clear) begin
            cnt       <= '0;
            repeating <= 1'b0;
         end else if (rise) begin
            cnt       <= ONE_C;
            repeating <= 1'b0;
         end else if (delay_hit || rate_hit) begin
            cnt       <= ONE_C;
            repeating <= 1'b1;
         end else if (cnt != '0) begin
            cnt <= cnt + ONE_C;
         end
      end
   end

endmodule

// File: rtl/edit_field_sequencer.sv
// Run/edit sequencer for a clock-calendar: in RUN the 1 Hz tick advances
// the seconds counter with carries; in EDIT the buttons step one field.
module edit_field_sequencer
   import edit_field_sequencer_pkg::*;
#(
   parameter int REP_DELAY = 50_000_000,
   parameter int REP_RATE  = 10_000_000
) (
   input  logic       Clock_in,
   input  logic       Reset_in,
   input  logic       Tick_1s,
   input  logic       Btn_Edit,
   input  logic       Btn_Next,
   input  logic       Btn_Up,
   input  logic       Btn_Dw,
   input  logic       Sec_max,
   input  logic       Min_max,
   input  logic       Hr_max,
   input  logic       Day_max,
   input  logic       Mon_max,
   output logic       Up,
   output logic       Dw,
   output logic       STC,
   output logic       MTC,
   output logic       HTC,
   output logic       DF,
   output logic       MF,
   output logic       AF,
   output logic       Edit,
   output logic [2:0] Field
);

   seq_state_t state;
   logic       prev_edit;
   logic       prev_next;
   logic       edit_rise;
   logic       next_rise;
   logic       up_req;
   logic       dw_req;
   logic       rep_clear;
   logic       up_q;
   logic       dw_q;
   logic       edit_q;
   logic [2:0] field_q;
   logic [5:0] en_q;
   logic [5:0] run_en;

   assign edit_rise = Btn_Edit & ~prev_edit;
   assign next_rise = Btn_Next & ~prev_next;

   // Repeat timing only matters while editing; both buttons together or
   // leaving edit mode also abandon any hold in progress.
   assign rep_clear = (state != EDIT) | (Btn_Up & Btn_Dw) | edit_rise;

   // Ripple carry for a one-second step: each stage enables when all
   // lower counters are at their terminal value.
   assign run_en[0] = 1'b1;
   assign run_en[1] = Sec_max;
   assign run_en[2] = run_en[1] & Min_max;
   assign run_en[3] = run_en[2] & Hr_max;
   assign run_en[4] = run_en[3] & Day_max;
   assign run_en[5] = run_en[4] & Mon_max;

   btn_repeat #(
      .REP_DELAY (REP_DELAY),
      .REP_RATE  (REP_RATE)
   ) u_rep_up (
      .clk       (Clock_in),
      .rst_n     (Reset_in),
      .btn       (Btn_Up),
      .clear     (rep_clear),
      .pulse_req (up_req)
   );

   btn_repeat #(
      .REP_DELAY (REP_DELAY),
      .REP_RATE  (REP_RATE)
   ) u_rep_dw (
      .clk       (Clock_in),
      .rst_n     (Reset_in),
      .btn       (Btn_Dw),
      .clear     (rep_clear),
      .pulse_req (dw_req)
   );

   // Mode FSM with all outputs registered; pulses default low each cycle
   always_ff @(posedge Clock_in or negedge Reset_in) begin
      if (!Reset_in) begin
         state     <= RUN;
         prev_edit <= 1'b1;
         prev_next <= 1'b1;
         up_q      <= 1'b0;
         dw_q      <= 1'b0;
         en_q      <= 6'b000000;
         edit_q    <= 1'b0;
         field_q   <= FLD_SEG;
      end else begin
         prev_edit <= Btn_Edit;
         prev_next <= Btn_Next;
         up_q      <= 1'b0;
         dw_q      <= 1'b0;
         en_q      <= 6'b000000;
         case (state)
            RUN: begin
               if (Tick_1s) begin
                  up_q <= 1'b1;
                  en_q <= run_en;
               end
               if (edit_rise) begin
                  state   <= EDIT;
                  edit_q  <= 1'b1;
                  field_q <= FLD_SEG;
               end
            end
            EDIT: begin
               if (edit_rise) begin
                  state   <= RUN;
                  edit_q  <= 1'b0;
                  field_q <= FLD_SEG;
               end else if (next_rise) begin
                  field_q <= next_field(field_q);
               end else if (up_req && !dw_req) begin
                  up_q <= 1'b1;
                  en_q <= field_enable(field_q);
               end else if (dw_req && !up_req) begin
                  dw_q <= 1'b1;
                  en_q <= field_enable(field_q);
               end
            end
            default: begin
               state   <= RUN;
               edit_q  <= 1'b0;
               field_q <= FLD_SEG;
            end
         endcase
      end
   end

   assign Up    = up_q;
   assign Dw    = dw_q;
   assign STC   = en_q[0];
   assign MTC   = en_q[1];
   assign HTC   = en_q[2];
   assign DF    = en_q[3];
   assign MF    = en_q[4];
   assign AF    = en_q[5];
   assign Edit  = edit_q;
   assign Field = field_q;

endmodule

// File: tb/tb_edit_field_sequencer.sv
// Directed bench for edit_field_sequencer with short repeat timing.
module tb_edit_field_sequencer;

   localparam int REP_DELAY = 8;
   localparam int REP_RATE  = 4;

   logic       Clock_in = 1'b0;
   logic       Reset_in;
   logic       Tick_1s, Btn_Edit, Btn_Next, Btn_Up, Btn_Dw;
   logic       Sec_max, Min_max, Hr_max, Day_max, Mon_max;
   logic       Up, Dw, STC, MTC, HTC, DF, MF, AF, Edit;
   logic [2:0] Field;

   int testsRun    = 0;
   int testsFailed = 0;

   // btns = {tick, edit, next, up, dw}; maxv = {mon, day, hr, min, sec}
   // ud = {Up, Dw}; en = {AF, MF, DF, HTC, MTC, STC}
   typedef struct {
      logic [4:0] btns;
      logic [4:0] maxv;
      logic [1:0] ud;
      logic [5:0] en;
      logic       edit;
      logic [2:0] field;
   } vec_t;

   vec_t vecs[$];

   edit_field_sequencer #(
      .REP_DELAY (REP_DELAY),
      .REP_RATE  (REP_RATE)
   ) dut (
      .Clock_in (Clock_in),
      .Reset_in (Reset_in),
      .Tick_1s  (Tick_1s),
      .Btn_Edit (Btn_Edit),
      .Btn_Next (Btn_Next),
      .Btn_Up   (Btn_Up),
      .Btn_Dw   (Btn_Dw),
      .Sec_max  (Sec_max),
      .Min_max  (Min_max),
      .Hr_max   (Hr_max),
      .Day_max  (Day_max),
      .Mon_max  (Mon_max),
      .Up       (Up),
      .Dw       (Dw),
      .STC      (STC),
      .MTC      (MTC),
      .HTC      (HTC),
      .DF       (DF),
      .MF       (MF),
      .AF       (AF),
      .Edit     (Edit),
      .Field    (Field)
   );

   always #5 Clock_in = ~Clock_in;

   task automatic tick();
      @(posedge Clock_in);
      #1;
   endtask

   task automatic applyStimulus(input logic [4:0] btns, input logic [4:0] maxv);
      {Tick_1s, Btn_Edit, Btn_Next, Btn_Up, Btn_Dw} = btns;
      {Mon_max, Day_max, Hr_max, Min_max, Sec_max} = maxv;
   endtask

   task automatic checkOutput(input string name, input logic [1:0] expUd,
                              input logic [5:0] expEn, input logic expEdit,
                              input logic [2:0] expField);
      logic [11:0] got;
      logic [11:0] want;
      got  = {Up, Dw, AF, MF, DF, HTC, MTC, STC, Edit, Field};
      want = {expUd, expEn, expEdit, expField};
      testsRun++;
      if (got !== want) begin
         testsFailed++;
         $display("[TB] FAIL %s: got ud=%b en=%b edit=%b field=%0d, want ud=%b en=%b edit=%b field=%0d",
                  name, got[11:10], got[9:4], got[3], got[2:0],
                  want[11:10], want[9:4], want[3], want[2:0]);
      end
   endtask

   task automatic addVec(input logic [4:0] btns, input logic [4:0] maxv,
                         input logic [1:0] ud, input logic [5:0] en,
                         input logic edit, input logic [2:0] field);
      vec_t v;
      v.btns = btns; v.maxv = maxv; v.ud = ud; v.en = en;
      v.edit = edit; v.field = field;
      vecs.push_back(v);
   endtask

   initial begin
      logic pulse;

      // Vector table: one cycle per entry, outputs checked one cycle later
      addVec(5'b00000, 5'b00000, 2'b00, 6'b000000, 1'b0, 3'd0);
      addVec(5'b10000, 5'b00011, 2'b10, 6'b000111, 1'b0, 3'd0);
      addVec(5'b00000, 5'b00011, 2'b00, 6'b000000, 1'b0, 3'd0);
      addVec(5'b10000, 5'b01111, 2'b10, 6'b011111, 1'b0, 3'd0);
      addVec(5'b10000, 5'b11110, 2'b10, 6'b000001, 1'b0, 3'd0);
      addVec(5'b01000, 5'b00000, 2'b00, 6'b000000, 1'b1, 3'd0);
      addVec(5'b00000, 5'b00000, 2'b00, 6'b000000, 1'b1, 3'd0);
      addVec(5'b00100, 5'b00000, 2'b00, 6'b000000, 1'b1, 3'd1);
      addVec(5'b00000, 5'b00000, 2'b00, 6'b000000, 1'b1, 3'd1);
      addVec(5'b00100, 5'b00000, 2'b00, 6'b000000, 1'b1, 3'd2);
      addVec(5'b00000, 5'b00000, 2'b00, 6'b000000, 1'b1, 3'd2);
      addVec(5'b00100, 5'b00000, 2'b00, 6'b000000, 1'b1, 3'd3);
      addVec(5'b00000, 5'b00000, 2'b00, 6'b000000, 1'b1, 3'd3);
      addVec(5'b00010, 5'b00000, 2'b10, 6'b001000, 1'b1, 3'd3);
      addVec(5'b00000, 5'b00000, 2'b00, 6'b000000, 1'b1, 3'd3);
      addVec(5'b10000, 5'b11111, 2'b00, 6'b000000, 1'b1, 3'd3);
      addVec(5'b00001, 5'b00000, 2'b01, 6'b001000, 1'b1, 3'd3);
      addVec(5'b00000, 5'b00000, 2'b00, 6'b000000, 1'b1, 3'd3);
      addVec(5'b00100, 5'b00000, 2'b00, 6'b000000, 1'b1, 3'd4);
      addVec(5'b00000, 5'b00000, 2'b00, 6'b000000, 1'b1, 3'd4);
      addVec(5'b00100, 5'b00000, 2'b00, 6'b000000, 1'b1, 3'd5);
      addVec(5'b00000, 5'b00000, 2'b00, 6'b000000, 1'b1, 3'd5);
      addVec(5'b00100, 5'b00000, 2'b00, 6'b000000, 1'b1, 3'd0);
      addVec(5'b00000, 5'b00000, 2'b00, 6'b000000, 1'b1, 3'd0);
      addVec(5'b00011, 5'b00000, 2'b00, 6'b000000, 1'b1, 3'd0);
      addVec(5'b00000, 5'b00000, 2'b00, 6'b000000, 1'b1, 3'd0);
      addVec(5'b00110, 5'b00000, 2'b00, 6'b000000, 1'b1, 3'd1);
      addVec(5'b00000, 5'b00000, 2'b00, 6'b000000, 1'b1, 3'd1);
      addVec(5'b01010, 5'b00000, 2'b00, 6'b000000, 1'b0, 3'd0);
      addVec(5'b00000, 5'b00000, 2'b00, 6'b000000, 1'b0, 3'd0);
      addVec(5'b00010, 5'b00000, 2'b00, 6'b000000, 1'b0, 3'd0);
      addVec(5'b00000, 5'b00000, 2'b00, 6'b000000, 1'b0, 3'd0);
      addVec(5'b11000, 5'b00001, 2'b10, 6'b000011, 1'b1, 3'd0);
      addVec(5'b00000, 5'b00000, 2'b00, 6'b000000, 1'b1, 3'd0);
      addVec(5'b00100, 5'b00000, 2'b00, 6'b000000, 1'b1, 3'd1);
      addVec(5'b00000, 5'b00000, 2'b00, 6'b000000, 1'b1, 3'd1);

      // Reset with Btn_Edit held: no edge may be seen after release
      Reset_in = 1'b0;
      applyStimulus(5'b01000, 5'b00000);
      repeat (3) @(posedge Clock_in);
      #1;
      checkOutput("reset_state", 2'b00, 6'b000000, 1'b0, 3'd0);
      @(negedge Clock_in);
      Reset_in = 1'b1;
      tick();
      checkOutput("edit_held_through_reset", 2'b00, 6'b000000, 1'b0, 3'd0);
      applyStimulus(5'b00000, 5'b00000);
      tick();

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].btns, vecs[i].maxv);
         tick();
         checkOutput($sformatf("vec%0d", i), vecs[i].ud, vecs[i].en,
                     vecs[i].edit, vecs[i].field);
      end

      // Hold Dw 20 cycles on the minutes field: pulses at 1, 9, 13, 17
      applyStimulus(5'b00001, 5'b00000);
      for (int n = 1; n <= 28; n++) begin
         tick();
         if (n == 20) applyStimulus(5'b00000, 5'b00000);
         pulse = (n == 1) || (n == 9) || (n == 13) || (n == 17);
         checkOutput($sformatf("dw_hold_c%0d", n), {1'b0, pulse},
                     pulse ? 6'b000010 : 6'b000000, 1'b1, 3'd1);
      end

      // Hold Up into its first repeat, then reset asynchronously
      applyStimulus(5'b00010, 5'b00000);
      for (int n = 1; n <= 9; n++) begin
         tick();
         pulse = (n == 1) || (n == 9);
         checkOutput($sformatf("up_hold_c%0d", n), {pulse, 1'b0},
                     pulse ? 6'b000010 : 6'b000000, 1'b1, 3'd1);
      end
      #2;
      Reset_in = 1'b0;
      #1;
      checkOutput("reset_async", 2'b00, 6'b000000, 1'b0, 3'd0);
      @(posedge Clock_in);
      @(negedge Clock_in);
      Reset_in = 1'b1;
      for (int n = 1; n <= 12; n++) begin
         tick();
         checkOutput($sformatf("held_after_reset_c%0d", n), 2'b00, 6'b000000, 1'b0, 3'd0);
      end
      applyStimulus(5'b01010, 5'b00000);
      tick();
      checkOutput("edit_with_up_held", 2'b00, 6'b000000, 1'b1, 3'd0);
      applyStimulus(5'b00010, 5'b00000);
      for (int n = 1; n <= 10; n++) begin
         tick();
         checkOutput($sformatf("held_in_edit_c%0d", n), 2'b00, 6'b000000, 1'b1, 3'd0);
      end
      applyStimulus(5'b00000, 5'b00000);
      tick();
      checkOutput("up_released", 2'b00, 6'b000000, 1'b1, 3'd0);
      applyStimulus(5'b00010, 5'b00000);
      tick();
      checkOutput("repress_after_reset", 2'b10, 6'b000001, 1'b1, 3'd0);
      applyStimulus(5'b00000, 5'b00000);
      tick();
      checkOutput("repress_one_cycle", 2'b00, 6'b000000, 1'b1, 3'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
